// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding a single UART transmit byte stream.
// A grant is held for a whole packet (until tlast or MAX_BEATS beats), then an
// optional idle gap is inserted before the next arbitration round.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]            req_tvalid,
  input  logic [NUM_REQ-1:0]            req_tlast,
  output logic [NUM_REQ-1:0]            req_tready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_valid,
  input  logic                          tx_data_ready,
  output logic                          tx_last,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          truncated
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BEATS - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 truncated_q, truncated_d;

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        cand;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 at_max;
  logic                 beat_acc;
  logic                 beat_final;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_found && req_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Mux the granted requester's lane.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IW'(i)) begin
        sel_data  = req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = req_tvalid[i];
        sel_last  = req_tlast[i];
      end
    end
  end

  // Pass-through datapath, only live while a grant is held.
  always_comb begin
    tx_data       = '0;
    tx_data_valid = 1'b0;
    tx_last       = 1'b0;
    req_tready    = '0;
    at_max        = (beat_q == LAST_CNT);
    beat_acc      = 1'b0;
    beat_final    = 1'b0;
    if (state_q == XFER) begin
      tx_data       = sel_data;
      tx_data_valid = sel_valid;
      tx_last       = sel_valid & (sel_last | at_max);
      req_tready    = grant_q & {NUM_REQ{tx_data_ready}};
      beat_acc      = sel_valid & tx_data_ready;
      beat_final    = beat_acc & (sel_last | at_max);
    end
  end

  // Next-state: arbitrate in IDLE, count beats in XFER, count down in GAP.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    truncated_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          beat_d            = '0;
          state_d           = XFER;
        end
      end
      XFER: begin
        if (beat_acc) begin
          if (beat_final) begin
            grant_d     = '0;
            rr_ptr_d    = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
            beat_d      = '0;
            truncated_d = ~sel_last;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      truncated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      truncated_q <= truncated_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign truncated = truncated_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester packet queues drive the
// inputs, expected beats are queued in hand-computed order, and a monitor pops
// and compares every accepted beat.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] req_tdata;
  logic [3:0]  req_tvalid;
  logic [3:0]  req_tlast;
  logic [3:0]  req_tready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic        tx_last;
  logic [3:0]  grant;
  logic        busy;
  logic        truncated;

  uart_tx_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BEATS (16),
    .GAP_CYCLES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_tdata    (req_tdata),
    .req_tvalid   (req_tvalid),
    .req_tlast    (req_tlast),
    .req_tready   (req_tready),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .tx_last      (tx_last),
    .grant        (grant),
    .busy         (busy),
    .truncated    (truncated)
  );

  typedef struct packed {
    logic [1:0] r;
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  dq[4][$];
  int unsigned beat_cyc[$];
  int unsigned cyc;
  int unsigned n_vec;
  int unsigned n_err;
  int unsigned trunc_cnt;
  int unsigned trunc_cyc;
  int unsigned busy_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drv(input int r, input logic [7:0] d, input logic l);
    dq[r].push_back({l, d});
  endtask

  task automatic expb(input int r, input logic [7:0] d, input logic l);
    exp_t e;
    e.r = 2'(r);
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  function automatic bit drv_empty();
    for (int i = 0; i < 4; i++) if (dq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input int unsigned budget, input bit need_idle);
    int unsigned n;
    bit          done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && drv_empty() && (!need_idle || !busy);
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) dq[i].delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Requester driver: pop a beat after each handshake, present the next one.
  initial begin
    logic [3:0] hs;
    logic [8:0] f;
    req_tvalid = '0;
    req_tlast  = '0;
    req_tdata  = '0;
    forever begin
      @(negedge clk);
      hs = req_tvalid & req_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i] && dq[i].size() != 0) void'(dq[i].pop_front());
        if (dq[i].size() != 0) begin
          f = dq[i][0];
          req_tvalid[i]          = 1'b1;
          req_tlast[i]           = f[8];
          req_tdata[i*8 +: 8]    = f[7:0];
        end else begin
          req_tvalid[i]          = 1'b0;
          req_tlast[i]           = 1'b0;
          req_tdata[i*8 +: 8]    = 8'h00;
        end
      end
    end
  end

  // Monitor: check handshake invariants every cycle, score accepted beats.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("tready_mirror", 32'(req_tready), 32'(grant & {4{tx_data_ready}}));
      if (grant == 4'b0000)
        chk("no_grant_outputs", {22'd0, tx_data_valid, tx_last, tx_data}, 32'd0);
      if (truncated) begin
        trunc_cnt++;
        trunc_cyc = cyc;
      end
      if (tx_data_valid && tx_data_ready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(tx_data), 32'(e.d));
          chk("beat_last", 32'(tx_last), 32'(e.l));
          chk("beat_grant", 32'(grant), 32'(4'b0001 << e.r));
        end
      end
    end
  end

  initial begin
    n_vec         = 0;
    n_err         = 0;
    trunc_cnt     = 0;
    trunc_cyc     = 0;
    reset         = 1'b1;
    tx_data_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {12'd0, tx_data_valid, tx_last, req_tready, tx_data, grant, busy, truncated}, 32'd0);
    reset = 1'b0;

    // Single requester 1, three beats, gap of two.
    tx_data_ready = 1'b1;
    @(negedge clk);
    beat_cyc.delete();
    drv(1, 8'hA1, 0); drv(1, 8'hA2, 0); drv(1, 8'hA3, 1);
    expb(1, 8'hA1, 0); expb(1, 8'hA2, 0); expb(1, 8'hA3, 1);
    @(posedge clk); #3;
    chk("t1_pre_grant", 32'(grant), 32'd0);
    @(posedge clk); #3;
    chk("t1_grant", 32'(grant), 32'b0010);
    chk("t1_busy", 32'(busy), 32'd1);
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("t1_busy_cycles", busy_cnt, 5);
    chk("t1_back_to_back", beat_cyc[2] - beat_cyc[0], 2);
    chk("t1_drained", exp_q.size(), 0);

    // Requesters 0 and 2 together; 0 has a second packet queued.
    do_reset();
    @(negedge clk);
    beat_cyc.delete();
    drv(0, 8'hB0, 0); drv(0, 8'hB1, 1); drv(0, 8'hB2, 0); drv(0, 8'hB3, 1);
    drv(2, 8'hC0, 0); drv(2, 8'hC1, 1);
    expb(0, 8'hB0, 0); expb(0, 8'hB1, 1);
    expb(2, 8'hC0, 0); expb(2, 8'hC1, 1);
    expb(0, 8'hB2, 0); expb(0, 8'hB3, 1);
    wait_drain(100, 1);
    chk("t2_intra_pkt", beat_cyc[1] - beat_cyc[0], 1);
    chk("t2_turnaround_a", beat_cyc[2] - beat_cyc[1], 4);
    chk("t2_turnaround_b", beat_cyc[4] - beat_cyc[3], 4);

    // All four continuously valid with 1-beat packets: 0,1,2,3 three times.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 4; r++) begin
        drv(r, 8'(16 * r + k), 1);
        expb(r, 8'(16 * r + k), 1);
      end
    wait_drain(200, 1);

    // Requester 3, 20 beats without tlast: forced release after 16.
    do_reset();
    @(negedge clk);
    beat_cyc.delete();
    trunc_cnt = 0;
    for (int b = 1; b <= 20; b++) begin
      drv(3, 8'(8'h40 + b), 0);
      expb(3, 8'(8'h40 + b), (b == 16) ? 1'b1 : 1'b0);
    end
    wait_drain(200, 0);
    repeat (3) @(negedge clk);
    chk("t4_trunc_count", trunc_cnt, 1);
    chk("t4_trunc_timing", trunc_cyc, beat_cyc[15] + 1);
    chk("t4_rearb_gap", beat_cyc[16] - beat_cyc[15], 4);
    chk("t4_grant_held", 32'(grant), 32'b1000);
    chk("t4_busy_held", 32'(busy), 32'd1);

    // Backpressure 1,0,0,1,1 during a 3-beat packet from requester 1.
    do_reset();
    tx_data_ready = 1'b0;
    @(negedge clk);
    beat_cyc.delete();
    drv(1, 8'hD0, 0); drv(1, 8'hD1, 0); drv(1, 8'hD2, 1);
    expb(1, 8'hD0, 0); expb(1, 8'hD1, 0); expb(1, 8'hD2, 1);
    @(posedge clk);
    @(posedge clk); #1;
    tx_data_ready = 1'b1;
    @(posedge clk); #1; tx_data_ready = 1'b0;
    @(posedge clk); #1; tx_data_ready = 1'b0;
    @(posedge clk); #1; tx_data_ready = 1'b1;
    @(posedge clk); #1; tx_data_ready = 1'b1;
    wait_drain(50, 1);
    chk("t5_beat_count", beat_cyc.size(), 3);
    chk("t5_stall_span", beat_cyc[1] - beat_cyc[0], 3);
    chk("t5_resume", beat_cyc[2] - beat_cyc[1], 1);

    // Reset during beat 2 of a 4-beat packet; rr_ptr must restart at 0.
    do_reset();
    tx_data_ready = 1'b1;
    @(negedge clk);
    drv(2, 8'h60, 1);
    expb(2, 8'h60, 1);
    wait_drain(50, 1);
    @(negedge clk);
    drv(1, 8'h71, 0); drv(1, 8'h72, 0); drv(1, 8'h73, 0); drv(1, 8'h74, 1);
    expb(1, 8'h71, 0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #2;
    chk("t6_mid_packet_data", 32'(tx_data), 32'h72);
    reset = 1'b1;
    #1;
    chk("t6_reset_outputs",
        {12'd0, tx_data_valid, tx_last, req_tready, tx_data, grant, busy, truncated}, 32'd0);
    dq[1].delete();
    @(negedge clk);
    @(negedge clk);
    drv(2, 8'h81, 1); drv(3, 8'h91, 1);
    expb(2, 8'h81, 1); expb(3, 8'h91, 1);
    reset = 1'b0;
    wait_drain(60, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
